// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: takes one byte on a valid/ready handshake and shifts it out
// LSB-first as start, data, parity and stop bits, each bit held CLKS_PER_BIT clock cycles.
module even_parity_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              parity_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              parity_q;

  logic accept;
  logic bit_done;
  logic stop_done;

  assign accept    = (state == IDLE) && in_valid;
  assign bit_done  = (clk_cnt == BIT_LAST);
  assign stop_done = (clk_cnt == STOP_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of the order of statements or blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no path
  // through the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && (bit_cnt == DATA_LAST)) state_nxt = PARITY;
      PARITY:  if (bit_done) state_nxt = STOP;
      STOP:    if (stop_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift register is reset as well, so an aborted frame leaves no stale
  // byte behind; it is small enough that this costs nothing worth avoiding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      parity_q <= 1'b0;
    end else if (accept) begin
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= in_data;
      parity_q <= ^in_data;
    end else if (state != IDLE) begin
      // The stop phase spans all stop bits as one long bit; every other phase is one bit.
      if ((state == STOP) ? stop_done : bit_done) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
      if ((state == DATA) && bit_done) begin
        shreg   <= shreg >> 1;
        bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + BIT_W'(1);
      end
    end
  end

  always_comb begin
    tx_out = 1'b1;
    case (state)
      IDLE:    tx_out = 1'b1;
      START:   tx_out = 1'b0;
      DATA:    tx_out = shreg[0];
      PARITY:  tx_out = parity_q;
      STOP:    tx_out = 1'b1;
      default: tx_out = 1'b1;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign parity_out = parity_q;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Bench for even_parity_serial_tx: a default-parameter instance and a CLKS_PER_BIT=1,
// STOP_BITS=2 instance, driven from a byte table and checked through a frame scoreboard.
module tb_even_parity_serial_tx;

  localparam int CPB_A  = 4;
  localparam int STOP_A = 1;
  localparam int CPB_B  = 1;
  localparam int STOP_B = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_a = '0;
  logic [7:0] data_b = '0;
  logic       valid_a = 1'b0;
  logic       valid_b = 1'b0;
  logic       rdy_a, tx_a, par_a, busy_a;
  logic       rdy_b, tx_b, par_b, busy_b;

  always #5 clk = ~clk;

  even_parity_serial_tx #(
    .DATA_W(8), .CLKS_PER_BIT(CPB_A), .STOP_BITS(STOP_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(data_a), .in_valid(valid_a),
    .in_ready(rdy_a), .tx_out(tx_a), .parity_out(par_a), .busy(busy_a)
  );

  even_parity_serial_tx #(
    .DATA_W(8), .CLKS_PER_BIT(CPB_B), .STOP_BITS(STOP_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(data_b), .in_valid(valid_b),
    .in_ready(rdy_b), .tx_out(tx_b), .parity_out(par_b), .busy(busy_b)
  );

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
    bit         b2b;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic txv(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic rdyv(input int w);
    return (w == 0) ? rdy_a : rdy_b;
  endfunction

  function automatic logic parv(input int w);
    return (w == 0) ? par_a : par_b;
  endfunction

  function automatic logic busyv(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  // Reference frame, one bit per position: start, data LSB first, parity, stop bits.
  function automatic logic [11:0] build_frame(input logic [7:0] d, input int nstop);
    logic [11:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    f[9] = ^d;
    for (int s = 0; s < nstop; s++) f[10+s] = 1'b1;
    return f;
  endfunction

  // Presents a byte, holds in_valid until the handshake edge, then logs it as expected.
  task automatic send(input int which, input logic [7:0] d, input logic p);
    int waited;
    waited = 0;
    @(negedge clk);
    if (which == 0) begin data_a = d; valid_a = 1'b1; end
    else begin data_b = d; valid_b = 1'b1; end
    while (rdyv(which) !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", rdyv(which), 1);
    if (rdyv(which) !== 1'b1) return;
    @(posedge clk);
    sb_q.push_back('{data: d, exp_par: p});
  endtask

  task automatic drop_valid(input int which);
    @(negedge clk);
    if (which == 0) valid_a = 1'b0;
    else valid_b = 1'b0;
  endtask

  // Waits for a start bit, then samples every bit in its middle cycle.
  task automatic recv(input int which, input int cpb, input int nstop,
                      output logic [11:0] bits, output int gap, output int rdy_hi,
                      output logic par);
    int frame;
    frame  = (10 + nstop) * cpb;
    bits   = '0;
    gap    = 0;
    rdy_hi = 0;
    par    = 1'b0;
    @(negedge clk);
    while (txv(which) === 1'b1 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    check("start_seen", txv(which), 0);
    if (txv(which) !== 1'b0) return;
    for (int c = 0; c < frame; c++) begin
      if (c > 0) @(negedge clk);
      if (rdyv(which) !== 1'b0) rdy_hi++;
      if (c == 0) par = parv(which);
      if (c % cpb == cpb / 2) bits[c/cpb] = txv(which);
    end
  endtask

  task automatic frame_check(input int which, input int cpb, input int nstop,
                             input string name, input int gap_exp);
    logic [11:0] bits;
    int          gap;
    int          rdy_hi;
    logic        par;
    sb_t         e;
    recv(which, cpb, nstop, bits, gap, rdy_hi, par);
    check({name, "_ready_low"}, rdy_hi, 0);
    if (gap_exp >= 0) check({name, "_gap"}, gap, gap_exp);
    check({name, "_sb_nonempty"}, (sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check({name, "_frame"}, bits, build_frame(e.data, nstop));
    check({name, "_parity_bit"}, bits[9], e.exp_par);
    check({name, "_parity_out"}, par, e.exp_par);
    check({name, "_even"}, ^bits[9:1], 0);
  endtask

  task automatic post_idle(input int which, input string name);
    @(negedge clk);
    check({name, "_end_ready"}, rdyv(which), 1);
    check({name, "_end_tx"}, txv(which), 1);
    check({name, "_end_busy"}, busyv(which), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'h00, exp_par: 1'b0, b2b: 1'b0};
    vecs[1] = '{data: 8'h01, exp_par: 1'b1, b2b: 1'b1};
    vecs[2] = '{data: 8'h03, exp_par: 1'b0, b2b: 1'b1};
    vecs[3] = '{data: 8'h80, exp_par: 1'b1, b2b: 1'b1};
    vecs[4] = '{data: 8'hDF, exp_par: 1'b1, b2b: 1'b0};
    vecs[5] = '{data: 8'h55, exp_par: 1'b0, b2b: 1'b0};
    vecs[6] = '{data: 8'hFF, exp_par: 1'b0, b2b: 1'b0};
    vecs[7] = '{data: 8'h7E, exp_par: 1'b0, b2b: 1'b0};
    vecs[8] = '{data: 8'h10, exp_par: 1'b1, b2b: 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx_a", tx_a, 1);
    check("rst_ready_a", rdy_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_par_a", par_a, 0);
    check("rst_tx_b", tx_b, 1);
    check("rst_ready_b", rdy_b, 1);
    rst_n = 1'b1;

    // Single frames (all-zero byte, 7 ones, alternating, all ones, ...)
    for (int i = 0; i < 9; i++) begin
      if (!vecs[i].b2b) begin
        fork
          begin
            send(0, vecs[i].data, vecs[i].exp_par);
            drop_valid(0);
          end
          frame_check(0, CPB_A, STOP_A, $sformatf("single%0d", i), -1);
        join
        post_idle(0, $sformatf("single%0d", i));
      end
    end

    // Back-to-back with in_valid held: only the accept cycle between frames
    fork
      begin
        for (int i = 0; i < 9; i++)
          if (vecs[i].b2b) send(0, vecs[i].data, vecs[i].exp_par);
        drop_valid(0);
      end
      begin
        frame_check(0, CPB_A, STOP_A, "b2b0", -1);
        frame_check(0, CPB_A, STOP_A, "b2b1", 1);
        frame_check(0, CPB_A, STOP_A, "b2b2", 1);
      end
    join
    post_idle(0, "b2b");

    // New data and a valid pulse during a frame are ignored until in_ready returns
    fork
      begin
        send(0, 8'h3C, 1'b0);
        drop_valid(0);
        repeat (10) @(negedge clk);
        data_a  = 8'hC3;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        data_a  = 8'h5A;
        send(0, 8'hC3, 1'b0);
        drop_valid(0);
      end
      begin
        frame_check(0, CPB_A, STOP_A, "inflight", -1);
        frame_check(0, CPB_A, STOP_A, "after_busy", 1);
      end
    join
    post_idle(0, "after_busy");

    // One-edge reset in the middle of the data bits
    send(0, 8'hA7, 1'b1);
    drop_valid(0);
    repeat (7) @(negedge clk);
    check("mid_busy", busy_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx", tx_a, 1);
    check("abort_ready", rdy_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_par", par_a, 0);
    rst_n = 1'b1;
    check("abort_sb", sb_q.size(), 1);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    fork
      begin
        send(0, 8'h96, 1'b0);
        drop_valid(0);
      end
      frame_check(0, CPB_A, STOP_A, "post_abort", -1);
    join
    post_idle(0, "post_abort");

    // One cycle per bit, two stop bits
    fork
      begin
        send(1, 8'hAA, 1'b0);
        drop_valid(1);
      end
      frame_check(1, CPB_B, STOP_B, "fast", -1);
    join
    post_idle(1, "fast");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
